data_mmio_bridge: RTL and testbench
===================================

DATA_MMIO_BRIDGE -- requirements
Module: data_mmio_bridge

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
 - MMIO_BASE, 32'hBFAF_F000, base of the 4 KiB MMIO window
 - SW_WIDTH, 8, switch input width
REQ-002 SHALL have ports, one per line: name, direction, width, meaning:
 - clk, in, 1, sole clock
 - resetn, in, 1, asynchronous active-low reset
 - cpu_en, in, 1, CPU data request
 - cpu_we, in, 4, CPU byte write enables
 - cpu_addr, in, 32, CPU byte address
 - cpu_wdata, in, 32, CPU write data
 - cpu_rdata, out, 32, read data, valid the cycle after the request
 - ram_en, out, 1, data SRAM enable
 - ram_we, out, 4, data SRAM byte enables
 - ram_addr, out, 32, data SRAM address
 - ram_wdata, out, 32, data SRAM write data
 - ram_rdata, in, 32, data SRAM read data, 1-cycle latency
 - sw_in, in, SW_WIDTH, board switches
 - led_out, out, 16, LED register
 - timer_out, out, 32, free-running timer value
REQ-003 SHALL use one clock, clk; reset is asynchronous and active-low on resetn.

Function
REQ-004 SHALL decode hit_mmio = cpu_addr[31:12] == MMIO_BASE[31:12].
REQ-005 SHALL drive ram_en = cpu_en & ~hit_mmio and ram_we = cpu_we & {4{ram_en}}; ram_addr and ram_wdata SHALL pass through combinationally.
REQ-006 SHALL have a 1-cycle read latency, matching the SRAM: cpu_rdata in cycle N+1 reflects a request in cycle N.
REQ-007 SHALL register sel_mmio = cpu_en & hit_mmio at each clk edge; cpu_rdata SHALL equal mmio_rdata_q when sel_mmio=1, else ram_rdata.
REQ-008 SHALL implement these MMIO registers (offset = cpu_addr[11:0]):
 - 0x000 LED, 16 bits, RW
 - 0x004 SWITCH, RO, zero-extended sw_in sampled at the read edge
 - 0x008 TIMER, 32 bits, RW
 - 0x00C SCRATCH, 32 bits, RW
REQ-009 SHALL apply MMIO writes when cpu_en & hit_mmio & |cpu_we, honouring each byte lane of cpu_we; LED SHALL use lanes 0-1 only.
REQ-010 SHALL latch mmio_rdata_q on every cpu_en & hit_mmio cycle, including write cycles, with the register value before that cycle's write.
REQ-011 SHALL make unmapped offsets, unaligned offsets (addr[1:0]!=0) and upper-lane LED reads return 0; writes to them SHALL be ignored.
REQ-012 SHALL increment TIMER by 1 every cycle, wrapping 0xFFFF_FFFF->0; a same-cycle write SHALL win, storing the written bytes with unwritten bytes taking the incremented value.
REQ-013 SHALL make a write to SWITCH have no effect.
REQ-014 SHALL drive led_out = LED register and timer_out = TIMER register directly from flops.
REQ-015 SHALL, when cpu_en=0, not update sel_mmio's data path (sel_mmio<=0); cpu_rdata SHALL then follow ram_rdata.

Reset
REQ-016 SHALL set, on resetn=0, asynchronously: LED=0, TIMER=0, SCRATCH=0, sel_mmio=0, mmio_rdata_q=0.
REQ-017 SHALL drop any request in flight when reset is asserted mid-operation; cpu_rdata SHALL then equal ram_rdata.
REQ-018 SHALL hold TIMER at 0 while resetn=0 and have it count from the first edge after release.

Structure
REQ-019 SHALL put MMIO_BASE, the register offsets and LED width in a shared package/header (mycpu_head.v style defines).
REQ-020 SHALL place the register file and TIMER in one sub-module, mmio_regs; address decode and rdata mux SHALL stay in data_mmio_bridge.

Verification
REQ-021 RAM path: read 0x0000_1000, ram_rdata=0xDEADBEEF -> ram_en=1, cpu_rdata=0xDEADBEEF next cycle.
REQ-022 LED write: write 0xBFAF_F000, we=4'b0001, wdata=0x1234_56AB -> led_out=0x00AB, ram_en=0; readback=0x0000_00AB.
REQ-023 Timer wrap/priority: write TIMER=0xFFFF_FFFE, we=4'hF -> reads 0xFFFF_FFFF then 0x0000_0000 on following cycles; write at the same edge overrides increment.
REQ-024 Mux switching: back-to-back MMIO read of SCRATCH=0x5A5A5A5A then RAM read -> cpu_rdata=0x5A5A5A5A, then ram_rdata.
REQ-025 Unmapped/RO: read 0xBFAF_F010 -> 0; write SWITCH then read with sw_in=0x3C -> 0x0000_003C.
REQ-026 Async reset mid-access: assert resetn=0 between request and data edge -> LED/TIMER/SCRATCH=0 immediately, cpu_rdata follows ram_rdata.

Source files
------------

// File: rtl/data_mmio_bridge_pkg.sv
// Shared definitions for the data-side MMIO bridge: window base, register
// offsets, LED width, register selector and a byte-lane merge helper.
package data_mmio_bridge_pkg;

    // Default base of the 4 KiB MMIO window (only bits [31:12] are decoded).
    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hBFAF_F000;

    // Register offsets inside the window (byte addresses, word aligned).
    localparam logic [11:0] OFF_LED     = 12'h000;
    localparam logic [11:0] OFF_SWITCH  = 12'h004;
    localparam logic [11:0] OFF_TIMER   = 12'h008;
    localparam logic [11:0] OFF_SCRATCH = 12'h00C;

    // Width of the LED register; it occupies byte lanes 0-1 of its word.
    localparam int LED_W = 16;

    // Which register an MMIO offset selects; REG_NONE covers unmapped and
    // unaligned offsets, which read as zero and swallow writes.
    typedef enum logic [2:0] {
        REG_NONE    = 3'd0,
        REG_LED     = 3'd1,
        REG_SWITCH  = 3'd2,
        REG_TIMER   = 3'd3,
        REG_SCRATCH = 3'd4
    } mmio_reg_e;

    // Map a 12-bit window offset to a register. Exact match only, so any
    // offset with addr[1:0] != 0 falls through to REG_NONE.
    function automatic mmio_reg_e decode_offset(input logic [11:0] off);
        mmio_reg_e sel;
        sel = REG_NONE;
        case (off)
            OFF_LED:     sel = REG_LED;
            OFF_SWITCH:  sel = REG_SWITCH;
            OFF_TIMER:   sel = REG_TIMER;
            OFF_SCRATCH: sel = REG_SCRATCH;
            default:     sel = REG_NONE;
        endcase
        return sel;
    endfunction

    // Replace the byte lanes of old_val selected by be with those of new_val.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/data_mmio_bridge_mmio_regs.sv
// MMIO register file: LED (16 bits, lanes 0-1), free-running TIMER and
// SCRATCH. Writes arrive pre-decoded from the bridge; reads are taken
// straight from the register outputs by the bridge's read mux.
module mmio_regs
    import data_mmio_bridge_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  mmio_reg_e        wr_sel_i,
    input  logic [3:0]       wr_be_i,
    input  logic [31:0]      wr_data_i,
    output logic [LED_W-1:0] led_o,
    output logic [31:0]      timer_o,
    output logic [31:0]      scratch_o
);

    logic [LED_W-1:0] led_q,     led_d;
    logic [31:0]      timer_q,   timer_d;
    logic [31:0]      scratch_q, scratch_d;
    logic [31:0]      timer_inc;

    // The timer always advances; a write only overrides the lanes it names.
    assign timer_inc = timer_q + 32'd1;

    // Next-state for every register: hold (or count) unless written this cycle.
    always_comb begin
        led_d     = led_q;
        timer_d   = timer_inc;
        scratch_d = scratch_q;
        if (wr_en_i) begin
            case (wr_sel_i)
                REG_LED: begin
                    // Only lanes 0-1 exist for LED; upper-lane enables are dropped.
                    for (int b = 0; b < LED_W / 8; b++) begin
                        if (wr_be_i[b]) begin
                            led_d[8*b +: 8] = wr_data_i[8*b +: 8];
                        end
                    end
                end
                REG_TIMER:   timer_d   = merge_bytes(timer_inc, wr_data_i, wr_be_i);
                REG_SCRATCH: scratch_d = merge_bytes(scratch_q, wr_data_i, wr_be_i);
                default:     ; // SWITCH is read-only, REG_NONE is unmapped
            endcase
        end
    end

    // Register state; reset holds the timer at zero until release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            led_q     <= '0;
            timer_q   <= '0;
            scratch_q <= '0;
        end else begin
            led_q     <= led_d;
            timer_q   <= timer_d;
            scratch_q <= scratch_d;
        end
    end

    assign led_o     = led_q;
    assign timer_o   = timer_q;
    assign scratch_o = scratch_q;

endmodule

// File: rtl/data_mmio_bridge.sv
// Data-side bridge between the CPU data port and either the data SRAM or
// a small MMIO window.
//
// Request/response contract: a request is a single cycle with cpu_en=1;
// there is no backpressure. Its read data appears on cpu_rdata in the
// following cycle, matching the SRAM's fixed 1-cycle latency. Whether the
// returned word comes from the MMIO capture register or from ram_rdata is
// decided by sel_mmio_q, registered alongside the request.
module data_mmio_bridge
    import data_mmio_bridge_pkg::*;
#(
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT,
    parameter int          SW_WIDTH  = 8
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                cpu_en,
    input  logic [3:0]          cpu_we,
    input  logic [31:0]         cpu_addr,
    input  logic [31:0]         cpu_wdata,
    output logic [31:0]         cpu_rdata,
    output logic                ram_en,
    output logic [3:0]          ram_we,
    output logic [31:0]         ram_addr,
    output logic [31:0]         ram_wdata,
    input  logic [31:0]         ram_rdata,
    input  logic [SW_WIDTH-1:0] sw_in,
    output logic [15:0]         led_out,
    output logic [31:0]         timer_out
);

    logic             hit_mmio;
    logic             mmio_access;
    logic             mmio_write;
    mmio_reg_e        reg_sel;
    logic [LED_W-1:0] led_val;
    logic [31:0]      timer_val;
    logic [31:0]      scratch_val;
    logic [31:0]      mmio_read_val;
    logic             sel_mmio_q,   sel_mmio_d;
    logic [31:0]      mmio_rdata_q, mmio_rdata_d;

    // Window decode on the upper 20 address bits.
    assign hit_mmio    = (cpu_addr[31:12] == MMIO_BASE[31:12]);
    assign mmio_access = cpu_en & hit_mmio;
    assign mmio_write  = mmio_access & (|cpu_we);
    assign reg_sel     = decode_offset(cpu_addr[11:0]);

    // SRAM side: enable only outside the window, address/data pass through.
    assign ram_en    = cpu_en & ~hit_mmio;
    assign ram_we    = cpu_we & {4{ram_en}};
    assign ram_addr  = cpu_addr;
    assign ram_wdata = cpu_wdata;

    mmio_regs u_regs (
        .clk_i     (clk),
        .rst_ni    (resetn),
        .wr_en_i   (mmio_write),
        .wr_sel_i  (reg_sel),
        .wr_be_i   (cpu_we),
        .wr_data_i (cpu_wdata),
        .led_o     (led_val),
        .timer_o   (timer_val),
        .scratch_o (scratch_val)
    );

    // Current (pre-write) value of the addressed register; zero if unmapped.
    always_comb begin
        mmio_read_val = '0;
        case (reg_sel)
            REG_LED:     mmio_read_val = 32'(led_val);
            REG_SWITCH:  mmio_read_val = 32'(sw_in);
            REG_TIMER:   mmio_read_val = timer_val;
            REG_SCRATCH: mmio_read_val = scratch_val;
            default:     mmio_read_val = '0;
        endcase
    end

    // Capture MMIO read data on every window access, write cycles included.
    always_comb begin
        sel_mmio_d   = mmio_access;
        mmio_rdata_d = mmio_rdata_q;
        if (mmio_access) begin
            mmio_rdata_d = mmio_read_val;
        end
    end

    // Response-path registers; reset discards any request in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sel_mmio_q   <= 1'b0;
            mmio_rdata_q <= '0;
        end else begin
            sel_mmio_q   <= sel_mmio_d;
            mmio_rdata_q <= mmio_rdata_d;
        end
    end

    assign cpu_rdata = sel_mmio_q ? mmio_rdata_q : ram_rdata;
    assign led_out   = led_val;
    assign timer_out = timer_val;

endmodule

// File: tb/tb_data_mmio_bridge.sv
// Bench for data_mmio_bridge: directed scenarios followed by random traffic,
// checked against a register-level reference model of the MMIO window.
module tb_data_mmio_bridge;

    localparam logic [31:0] BASE = 32'hBFAF_F000;

    logic        clk;
    logic        resetn;
    logic        cpu_en;
    logic [3:0]  cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [7:0]  sw_in;
    logic [15:0] led_out;
    logic [31:0] timer_out;

    int n_cmp;
    int n_fail;

    // Reference model state
    logic [15:0] m_led;
    logic [31:0] m_timer;
    logic [31:0] m_scratch;
    logic [31:0] m_rd;
    bit          m_sel;

    data_mmio_bridge #(.MMIO_BASE(BASE), .SW_WIDTH(8)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cpu_en    (cpu_en),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .sw_in     (sw_in),
        .led_out   (led_out),
        .timer_out (timer_out)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_led = '0; m_timer = '0; m_scratch = '0; m_rd = '0; m_sel = 0;
    endtask

    // One clock edge of the window as seen from the register map.
    task automatic model_edge();
        logic        hit;
        logic [31:0] off;
        logic [31:0] pre;
        logic [31:0] nt;
        logic [31:0] tmp;
        hit = ((cpu_addr & 32'hFFFF_F000) == BASE);
        off = cpu_addr & 32'h0000_0FFF;
        pre = 32'h0;
        if      (off == 32'h0) pre = {16'h0, m_led};
        else if (off == 32'h4) pre = {24'h0, sw_in};
        else if (off == 32'h8) pre = m_timer;
        else if (off == 32'hC) pre = m_scratch;
        nt = m_timer + 32'd1;
        if (cpu_en && hit && cpu_we != 4'h0) begin
            if (off == 32'h0) begin
                tmp   = lanes({16'h0, m_led}, cpu_wdata, cpu_we & 4'b0011);
                m_led = tmp[15:0];
            end else if (off == 32'h8) begin
                nt = lanes(nt, cpu_wdata, cpu_we);
            end else if (off == 32'hC) begin
                m_scratch = lanes(m_scratch, cpu_wdata, cpu_we);
            end
        end
        m_timer = nt;
        if (cpu_en && hit) begin
            m_sel = 1;
            m_rd  = pre;
        end else begin
            m_sel = 0;
        end
    endtask

    // Called at posedge+2: drive a request, check the SRAM side, take the
    // edge, present the SRAM's answer and check the response.
    task automatic step(input logic en, input logic [3:0] we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rr);
        logic hit;
        hit       = ((addr & 32'hFFFF_F000) == BASE);
        cpu_en    = en;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        #1;
        check("ram_en", {31'h0, ram_en}, {31'h0, en & ~hit});
        check("ram_we", {28'h0, ram_we}, (en && !hit) ? {28'h0, we} : 32'h0);
        check("ram_addr", ram_addr, addr);
        check("ram_wdata", ram_wdata, wdata);
        @(posedge clk);
        model_edge();
        #1;
        ram_rdata = rr;
        #1;
        check("cpu_rdata", cpu_rdata, m_sel ? m_rd : rr);
        check("led_out", {16'h0, led_out}, {16'h0, m_led});
        check("timer_out", timer_out, m_timer);
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        resetn = 1'b0; cpu_en = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ram_rdata = 32'h1111_2222; sw_in = 8'h00;
        model_reset();

        // Reset state: timer held at zero across edges
        repeat (3) @(posedge clk);
        #1;
        check("rst_led", {16'h0, led_out}, 32'h0);
        check("rst_timer", timer_out, 32'h0);
        check("rst_rdata", cpu_rdata, 32'h1111_2222);
        check("rst_ram_en", {31'h0, ram_en}, 32'h0);
        #1;
        resetn = 1'b1;

        // RAM read path
        step(1, 4'h0, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF);
        check("ram_read_data", cpu_rdata, 32'hDEAD_BEEF);
        // LED byte write and readback
        step(1, 4'b0001, BASE, 32'h1234_56AB, 32'h0BAD_0001);
        check("led_write", {16'h0, led_out}, 32'h0000_00AB);
        step(1, 4'h0, BASE, 32'h0, 32'h0BAD_0002);
        check("led_readback", cpu_rdata, 32'h0000_00AB);
        // LED upper lanes do not exist
        step(1, 4'b1100, BASE, 32'hFFFF_FFFF, 32'h0BAD_0003);
        step(1, 4'h0, BASE, 32'h0, 32'h0BAD_0004);
        check("led_upper_lanes", cpu_rdata, 32'h0000_00AB);
        // Timer write, wrap and partial-lane priority
        step(1, 4'hF, BASE + 32'h8, 32'hFFFF_FFFE, 32'h0);
        check("timer_written", timer_out, 32'hFFFF_FFFE);
        step(1, 4'h0, BASE + 32'h8, 32'h0, 32'h0);
        step(1, 4'h0, BASE + 32'h8, 32'h0, 32'h0);
        check("timer_read_ffff", cpu_rdata, 32'hFFFF_FFFF);
        step(1, 4'h0, BASE + 32'h8, 32'h0, 32'h0);
        check("timer_read_wrap", cpu_rdata, 32'h0000_0000);
        step(1, 4'b0010, BASE + 32'h8, 32'h0000_7700, 32'h0);
        step(0, 4'h0, 32'h0, 32'h0, 32'h0);
        // Scratch then RAM back-to-back
        step(1, 4'hF, BASE + 32'hC, 32'h5A5A_5A5A, 32'h0);
        step(1, 4'h0, BASE + 32'hC, 32'h0, 32'h0);
        check("scratch_read", cpu_rdata, 32'h5A5A_5A5A);
        step(1, 4'h0, 32'h0000_2000, 32'h0, 32'hCAFE_F00D);
        check("mux_back_to_ram", cpu_rdata, 32'hCAFE_F00D);
        // Unmapped, unaligned, read-only
        step(1, 4'h0, BASE + 32'h10, 32'h0, 32'h0BAD_0005);
        check("unmapped_read", cpu_rdata, 32'h0);
        step(1, 4'hF, BASE + 32'hD, 32'hFFFF_FFFF, 32'h0);
        step(1, 4'h0, BASE + 32'h9, 32'h0, 32'h0BAD_0006);
        check("unaligned_read", cpu_rdata, 32'h0);
        step(1, 4'hF, BASE + 32'h4, 32'hFFFF_FFFF, 32'h0);
        sw_in = 8'h3C;
        step(1, 4'h0, BASE + 32'h4, 32'h0, 32'h0);
        check("switch_read", cpu_rdata, 32'h0000_003C);
        // Idle cycle: response follows SRAM
        step(0, 4'h0, BASE, 32'h0, 32'h7777_8888);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            logic [3:0]  w;
            int          pick;
            pick = $urandom_range(0, 6);
            if (pick <= 3)      a = BASE + 32'(4 * pick);
            else if (pick == 4) a = BASE + 32'($urandom_range(0, 1023) * 4);
            else if (pick == 5) a = BASE + 32'($urandom_range(0, 15));
            else                a = $urandom & 32'h7FFF_FFFF;
            w     = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            sw_in = 8'($urandom);
            step(($urandom_range(0, 4) != 0), w, a, $urandom, $urandom);
        end

        // Asynchronous reset in the middle of an MMIO access
        step(1, 4'hF, BASE + 32'hC, 32'h1357_9BDF, 32'h0);
        step(1, 4'h3, BASE, 32'h0000_BEEF, 32'h0);
        cpu_en = 1; cpu_we = 4'h0; cpu_addr = BASE + 32'h8;
        #2;
        resetn    = 1'b0;
        ram_rdata = 32'h2468_ACE0;
        #1;
        check("arst_led", {16'h0, led_out}, 32'h0);
        check("arst_timer", timer_out, 32'h0);
        check("arst_rdata", cpu_rdata, 32'h2468_ACE0);
        @(posedge clk);
        #1;
        check("arst_timer_held", timer_out, 32'h0);
        check("arst_rdata_held", cpu_rdata, 32'h2468_ACE0);
        #1;
        cpu_en = 0;
        model_reset();
        resetn = 1'b1;
        step(1, 4'h0, BASE + 32'hC, 32'h0, 32'h0);
        check("arst_scratch_cleared", cpu_rdata, 32'h0);
        step(1, 4'h0, BASE + 32'h8, 32'h0, 32'h0);
        check("arst_timer_counts", cpu_rdata, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
